// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: pause/run/adjust controller for a MM:SS stopwatch.
// Debounces the pause button, sequences the PAUSED/RUN/ADJUST modes and
// issues one-cycle count/adjust enables plus digit blanking to the datapath.
// Optional feature: define STOPWATCH_CTRL_AUTOSTOP_EN to stop a down-count at 00:00.
module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       btn_pause,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_blink,
    input  logic       dir,
    input  logic       sel,
    input  logic       adj,
    input  logic       at_zero,
    output logic       cnt_en,
    output logic       cnt_down,
    output logic       adj_min_en,
    output logic       adj_sec_en,
    output logic       clr,
    output logic [3:0] blank_mask,
    output logic       running,
    output logic [1:0] state
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        PAUSED  = 2'b00,
        RUN     = 2'b01,
        ADJUST  = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t           state_q;
    state_t           state_nx;
    logic [1:0]       sync_q;
    logic [1:0]       sync_vld_q;
    logic             deb_q;
    logic [CNT_W-1:0] deb_cnt_q;
    logic             press_q;
    logic             block_q;
    logic             phase_q;
    logic             phase_nx;
    logic             btn_sync;
    logic             autostop;

    assign btn_sync = sync_q[1];
    assign state    = state_q;

`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
    // A down-count tick that would run past 00:00 pauses the watch instead.
    assign autostop = (state_q == RUN) && tick_1hz && dir && at_zero;
`else
    logic at_zero_unused;
    assign at_zero_unused = at_zero;
    assign autostop       = 1'b0;
`endif

    // Synchronize and debounce the button; emit one press pulse per accepted rising level.
    // block_q swallows the rise of a button held through reset until it has been seen released.
    always_ff @(posedge clk) begin
        if (RESET) begin
            sync_q     <= 2'b00;
            sync_vld_q <= 2'b00;
            deb_q      <= 1'b0;
            deb_cnt_q  <= '0;
            press_q    <= 1'b0;
            block_q    <= 1'b1;
        end else begin
            sync_q     <= {sync_q[0], btn_pause};
            sync_vld_q <= {sync_vld_q[0], 1'b1};
            press_q    <= 1'b0;
            if (btn_sync != deb_q) begin
                if (deb_cnt_q == CNT_LAST) begin
                    deb_q     <= btn_sync;
                    deb_cnt_q <= '0;
                    press_q   <= btn_sync & ~block_q;
                end else begin
                    deb_cnt_q <= deb_cnt_q + CNT_W'(1);
                end
            end else begin
                deb_cnt_q <= '0;
            end
            if (sync_vld_q[1] && !btn_sync && !deb_q) begin
                block_q <= 1'b0;
            end
        end
    end

    // Mode transitions: adj wins over press, press is ignored while adjusting.
    always_comb begin
        state_nx = state_q;
        case (state_q)
            PAUSED: begin
                if (adj)          state_nx = ADJUST;
                else if (press_q) state_nx = RUN;
            end
            RUN: begin
                if (adj)                      state_nx = ADJUST;
                else if (press_q || autostop) state_nx = PAUSED;
            end
            ADJUST: begin
                if (!adj) state_nx = PAUSED;
            end
            default: state_nx = PAUSED;
        endcase
    end

    // Blink phase toggles only while already in ADJUST and is zero in any other mode.
    always_comb begin
        phase_nx = 1'b0;
        if (state_nx == ADJUST) begin
            phase_nx = (state_q == ADJUST && tick_blink) ? ~phase_q : phase_q;
        end
    end

    // State register and all registered outputs, aligned to the new state.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q    <= PAUSED;
            cnt_en     <= 1'b0;
            cnt_down   <= 1'b0;
            adj_min_en <= 1'b0;
            adj_sec_en <= 1'b0;
            clr        <= 1'b1;
            blank_mask <= 4'b0000;
            running    <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_nx;
            clr        <= 1'b0;
            cnt_en     <= (state_q == RUN) && tick_1hz && !autostop;
            cnt_down   <= dir;
            adj_min_en <= (state_q == ADJUST) && tick_2hz && !sel;
            adj_sec_en <= (state_q == ADJUST) && tick_2hz && sel;
            phase_q    <= phase_nx;
            running    <= (state_nx == RUN);
            if (state_nx == ADJUST && phase_nx) begin
                blank_mask <= sel ? 4'b0011 : 4'b1100;
            end else begin
                blank_mask <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table, directed multi-cycle sequences and
// a randomized run checked against a behavioural model (DEBOUNCE_CYCLES=4).
module tb_stopwatch_ctrl;

    localparam int unsigned DEB = 4;

    logic       clk = 1'b0;
    logic       RESET, btn_pause, tick_1hz, tick_2hz, tick_blink, dir, sel, adj, at_zero;
    logic       cnt_en, cnt_down, adj_min_en, adj_sec_en, clr, running;
    logic [3:0] blank_mask;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .RESET(RESET), .btn_pause(btn_pause), .tick_1hz(tick_1hz),
        .tick_2hz(tick_2hz), .tick_blink(tick_blink), .dir(dir), .sel(sel),
        .adj(adj), .at_zero(at_zero), .cnt_en(cnt_en), .cnt_down(cnt_down),
        .adj_min_en(adj_min_en), .adj_sec_en(adj_sec_en), .clr(clr),
        .blank_mask(blank_mask), .running(running), .state(state)
    );

    typedef struct {
        logic       adj, sel, dir, t1, t2, tb, az;
        logic [1:0] st;
        logic       ce, cd, amin, asec;
        logic [3:0] mask;
    } vec_t;

    vec_t tbl[13];

    // model state for the randomized run
    bit  hist[$];
    int  m_state, m_blinks, m_nx;
    bit  m_deb, m_press, m_new_press, m_all_diff, m_stop, m_phase;
    logic [11:0] m_exp;
    int  n;
    bit  reached;

    function automatic vec_t mk(input logic a, s, d, t1, t2, tb, az,
                                input logic [1:0] st, input logic ce, cd, amin, asec,
                                input logic [3:0] m);
        vec_t v;
        v.adj = a; v.sel = s; v.dir = d; v.t1 = t1; v.t2 = t2; v.tb = tb; v.az = az;
        v.st = st; v.ce = ce; v.cd = cd; v.amin = amin; v.asec = asec; v.mask = m;
        return v;
    endfunction

    function automatic logic [11:0] pk();
        return {state, running, cnt_en, cnt_down, adj_min_en, adj_sec_en, clr, blank_mask};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick_1hz = 1'b0; tick_2hz = 1'b0; tick_blink = 1'b0;
        dir = 1'b0; sel = 1'b0; adj = 1'b0; at_zero = 1'b0;
    endtask

    // press and release the button, expecting RUN within a bounded number of cycles
    task automatic press_to_run(input string name);
        bit ok;
        ok = 1'b0;
        btn_pause = 1'b1;
        for (int i = 0; i < 12 && !ok; i++) begin
            step();
            if (state == 2'b01) ok = 1'b1;
        end
        chk(name, 32'(ok), 32'd1);
        btn_pause = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1; btn_pause = 1'b0;
        idle();

        // reset behaviour
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst_hold%0d", i), 32'(pk()), 32'h010);
        end
        RESET = 1'b0;
        step();
        chk("rst_release", 32'(pk()), 32'h000);

        // vector table, starting PAUSED with blink phase 0
        tbl[0]  = mk(1,0,0,0,0,0,0, 2'd2, 0,0,0,0, 4'h0);
        tbl[1]  = mk(1,0,0,0,1,0,0, 2'd2, 0,0,1,0, 4'h0);
        tbl[2]  = mk(1,0,0,0,0,1,0, 2'd2, 0,0,0,0, 4'hC);
        tbl[3]  = mk(1,1,0,0,1,0,0, 2'd2, 0,0,0,1, 4'h3);
        tbl[4]  = mk(1,1,1,1,0,0,0, 2'd2, 0,1,0,0, 4'h3);
        tbl[5]  = mk(1,1,0,0,0,1,0, 2'd2, 0,0,0,0, 4'h0);
        tbl[6]  = mk(1,0,1,0,1,1,0, 2'd2, 0,1,1,0, 4'hC);
        tbl[7]  = mk(0,0,0,0,0,1,0, 2'd0, 0,0,0,0, 4'h0);
        tbl[8]  = mk(0,0,0,1,1,0,0, 2'd0, 0,0,0,0, 4'h0);
        tbl[9]  = mk(0,0,1,1,0,0,1, 2'd0, 0,1,0,0, 4'h0);
        tbl[10] = mk(1,1,0,0,0,1,0, 2'd2, 0,0,0,0, 4'h0);
        tbl[11] = mk(1,1,0,0,0,1,0, 2'd2, 0,0,0,0, 4'h3);
        tbl[12] = mk(0,1,0,0,1,0,0, 2'd0, 0,0,0,1, 4'h0);
        for (int i = 0; i < 13; i++) begin
            adj = tbl[i].adj; sel = tbl[i].sel; dir = tbl[i].dir; tick_1hz = tbl[i].t1;
            tick_2hz = tbl[i].t2; tick_blink = tbl[i].tb; at_zero = tbl[i].az;
            step();
            chk($sformatf("tbl%0d", i), 32'(pk()),
                32'({tbl[i].st, tbl[i].st == 2'd1, tbl[i].ce, tbl[i].cd, tbl[i].amin,
                     tbl[i].asec, 1'b0, tbl[i].mask}));
        end
        idle();

        // held button: one press 7 cycles after the edge, then 1 Hz counting
        btn_pause = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("press_lat%0d", i), 32'(state), (i >= 7) ? 32'd1 : 32'd0);
        end
        btn_pause = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick_1hz = (c % 20 == 19);
            step();
            chk($sformatf("cnt_en_c%0d", c), 32'(cnt_en), 32'(c % 20 == 19));
            chk($sformatf("run_c%0d", c), 32'(state), 32'd1);
        end
        tick_1hz = 1'b0;

        // bouncing button is rejected
        for (int i = 0; i < 20; i++) begin
            btn_pause = ((i / 2) % 2 == 0);
            step();
            chk($sformatf("bounce%0d", i), 32'(state), 32'd1);
        end
        btn_pause = 1'b0;
        repeat (10) step();
        chk("bounce_end", 32'(state), 32'd1);

        // adjust seconds from RUN
        adj = 1'b1; sel = 1'b1;
        step();
        chk("adj_enter", 32'(state), 32'd2);
        for (int k = 0; k < 3; k++) begin
            tick_2hz = 1'b1; tick_1hz = 1'b1;
            step();
            chk($sformatf("adj_pulse%0d", k), 32'({adj_sec_en, adj_min_en, cnt_en}), 32'b100);
            tick_2hz = 1'b0; tick_1hz = 1'b0;
            step();
            chk($sformatf("adj_gap%0d", k), 32'({adj_sec_en, adj_min_en, cnt_en}), 32'b000);
        end
        for (int k = 0; k < 4; k++) begin
            tick_blink = (k != 1);
            step();
            chk($sformatf("blink%0d", k), 32'(blank_mask), (k == 2) ? 32'h0 : 32'h3);
        end
        tick_blink = 1'b0; adj = 1'b0;
        step();
        chk("adj_exit", 32'({state, blank_mask}), 32'h00);
        idle();

        // press and tick in the same RUN cycle
        press_to_run("run_e");
        btn_pause = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk($sformatf("pt_wait%0d", i), 32'({state, cnt_en}), 32'b010);
        end
        tick_1hz = 1'b1;
        step();
        chk("pt_hit", 32'({state, cnt_en}), 32'b001);
        tick_1hz = 1'b0; btn_pause = 1'b0;
        step();
        chk("pt_after", 32'({state, cnt_en}), 32'b000);
        repeat (8) step();

        // down-count at 00:00
        press_to_run("run_f");
        dir = 1'b1; at_zero = 1'b0; tick_1hz = 1'b1;
        step();
        chk("down_nz", 32'({cnt_en, cnt_down, state}), 32'b1101);
        at_zero = 1'b1;
        step();
`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
        chk("down_zero", 32'({cnt_en, state}), 32'b000);
`else
        chk("down_zero", 32'({cnt_en, cnt_down, state}), 32'b1101);
`endif
        idle();

        // button held through reset must not press until released
        btn_pause = 1'b1;
        repeat (10) step();
        RESET = 1'b1;
        step(); step();
        chk("hold_rst", 32'({state, clr}), 32'b001);
        RESET = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("hold_after%0d", i), 32'(state), 32'd0);
        end
        btn_pause = 1'b0;
        repeat (10) step();
        chk("hold_released", 32'(state), 32'd0);
        btn_pause = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk($sformatf("repress%0d", i), 32'(state), (i == 7) ? 32'd1 : 32'd0);
        end
        btn_pause = 1'b0;
        repeat (8) step();

        // reset aborts ADJUST
        adj = 1'b1; tick_blink = 1'b1;
        step(); step();
        chk("adj_pre_rst", 32'({state, blank_mask}), 32'h2C);
        RESET = 1'b1;
        step();
        chk("adj_rst", 32'({state, running, blank_mask}), 32'h00);
        RESET = 1'b0; adj = 1'b0; tick_blink = 1'b0;
        step();
        chk("adj_rst_rel", 32'(pk()), 32'h000);

        // randomized run against the behavioural model
        RESET = 1'b1; btn_pause = 1'b0; idle();
        step(); step();
        RESET = 1'b0;
        hist.delete();
        for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b0);
        m_state = 0; m_deb = 1'b0; m_press = 1'b0; m_blinks = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i >= 3 && $urandom_range(6, 0) == 0) btn_pause = ~btn_pause;
            if ($urandom_range(49, 0) == 0) adj = ~adj;
            if ($urandom_range(7, 0) == 0) sel = ~sel;
            dir        = 1'($urandom_range(1, 0));
            at_zero    = ($urandom_range(3, 0) == 0);
            tick_1hz   = ($urandom_range(4, 0) == 0);
            tick_2hz   = ($urandom_range(3, 0) == 0);
            tick_blink = ($urandom_range(2, 0) == 0);

            // debounce: level flips once the last DEB synchronized samples all disagree
            hist.push_back(btn_pause);
            n = hist.size();
            m_all_diff = 1'b1;
            for (int j = 0; j < DEB; j++) if (hist[n - 3 - j] == m_deb) m_all_diff = 1'b0;
            m_new_press = m_all_diff && !m_deb;
            if (m_all_diff) m_deb = !m_deb;
            if (hist.size() > DEB + 4) void'(hist.pop_front());

            m_stop = 1'b0;
`ifdef STOPWATCH_CTRL_AUTOSTOP_EN
            m_stop = (m_state == 1) && tick_1hz && dir && at_zero;
`endif
            if (m_state == 2)      m_nx = adj ? 2 : 0;
            else if (adj)          m_nx = 2;
            else if (m_state == 0) m_nx = m_press ? 1 : 0;
            else                   m_nx = (m_press || m_stop) ? 0 : 1;

            if (m_nx == 2) begin
                if (m_state == 2 && tick_blink) m_blinks++;
            end else begin
                m_blinks = 0;
            end
            m_phase = (m_blinks % 2 == 1);
            m_exp = {2'(m_nx), m_nx == 1, (m_state == 1) && tick_1hz && !m_stop, dir,
                     (m_state == 2) && tick_2hz && !sel, (m_state == 2) && tick_2hz && sel,
                     1'b0, (m_nx == 2 && m_phase) ? (sel ? 4'h3 : 4'hC) : 4'h0};
            m_state = m_nx;
            m_press = m_new_press;

            step();
            chk($sformatf("rand%0d", i), 32'(pk()), 32'(m_exp));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
